// File: rtl/cpu_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings,
// FSM states and the architectural constants for the divide corner cases.
package cpu_muldiv_pkg;

    // funct3 encodings, aligned with the INST_ARLOG_* M-extension constants
    localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
    localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

    // Quotient returned for a zero divisor, and the dividend that overflows DIV
    localparam logic [31:0] MULDIV_DIV0_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [31:0] MULDIV_OVF_DIVIDEND  = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } muldiv_state_t;

    // Two's-complement negation when neg is set, pass-through otherwise
    function automatic logic [31:0] negate_if(input logic neg, input logic [31:0] value);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/cpu_muldiv_step.sv
// One iteration of the shared datapath. With is_div=0 it performs an
// unsigned shift-add multiply step ({hi,lo} holds partial product and the
// remaining multiplier bits); with is_div=1 it performs a restoring divide
// step (hi is the partial remainder, lo shifts dividend bits out and
// quotient bits in).
module cpu_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN+1:0] diff;
    logic            unused_diff_bit;

    // The remainder after a successful subtract is below the divisor, so
    // bit XLEN of the difference is always zero and never consumed.
    assign unused_diff_bit = diff[XLEN];

    // Compute both candidate updates and pick one by operation type
    always_comb begin
        sum       = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        rem_shift = {hi_in, lo_in[XLEN-1]};
        diff      = {1'b0, rem_shift} - {2'b00, operand};
        hi_out    = sum[XLEN:1];
        lo_out    = {sum[0], lo_in[XLEN-1:1]};
        if (is_div) begin
            if (!diff[XLEN+1]) begin
                hi_out = diff[XLEN-1:0];
                lo_out = {lo_in[XLEN-2:0], 1'b1};
            end else begin
                hi_out = rem_shift[XLEN-1:0];
                lo_out = {lo_in[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/cpu_muldiv.sv
// Multi-cycle RV32M multiply/divide unit. Operands are reduced to
// magnitudes on acceptance, iterated 32 times through cpu_muldiv_step and
// sign-corrected on the way into FINISH. Divide-by-zero and signed
// overflow are resolved immediately without iterating.
// Optional macro CPU_MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// 33x33 signed multiplier and skip the iterative path.
module cpu_muldiv
    import cpu_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_t state, next_state;

    logic [CNT_W-1:0] counter;
    logic [2:0]       op_q;
    logic [XLEN-1:0]  work_hi, work_lo, work_operand;
    logic             neg_result, neg_rem;

    logic             accept, bypass, special, last_iter;
    logic             a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag, bypass_value, special_value;
    logic [XLEN-1:0]  step_hi, step_lo, calc_result;
    logic [63:0]      product, product_fixed;

    // Request decode: signedness, magnitudes and the non-iterating cases
    always_comb begin
        accept   = (state == ST_IDLE || state == ST_FINISH) && start && !abort;
        a_signed = (op == MULDIV_OP_MULH) || (op == MULDIV_OP_MULHSU) ||
                   (op == MULDIV_OP_DIV)  || (op == MULDIV_OP_REM);
        b_signed = (op == MULDIV_OP_MULH) || (op == MULDIV_OP_DIV) || (op == MULDIV_OP_REM);
        a_neg    = a_signed && operand_a[XLEN-1];
        b_neg    = b_signed && operand_b[XLEN-1];
        a_mag    = negate_if(a_neg, operand_a);
        b_mag    = negate_if(b_neg, operand_b);
        special  = 1'b0;
        special_value = MULDIV_DIV0_QUOTIENT;
        if (op[2]) begin
            if (operand_b == '0) begin
                special       = 1'b1;
                special_value = op[1] ? operand_a : MULDIV_DIV0_QUOTIENT;
            end else if ((op == MULDIV_OP_DIV || op == MULDIV_OP_REM) &&
                         operand_a == MULDIV_OVF_DIVIDEND && operand_b == MULDIV_DIV0_QUOTIENT) begin
                special       = 1'b1;
                special_value = (op == MULDIV_OP_DIV) ? MULDIV_OVF_DIVIDEND : '0;
            end
        end
    end

`ifdef CPU_MULDIV_FAST_MUL_EN
    logic signed [32:0] fast_a, fast_b;
    logic signed [65:0] fast_full;
    logic [1:0]         unused_fast_bits;

    assign unused_fast_bits = fast_full[65:64];

    // Single-cycle multiply on sign- or zero-extended operands
    always_comb begin
        fast_a    = {a_signed & operand_a[XLEN-1], operand_a};
        fast_b    = {b_signed & operand_b[XLEN-1], operand_b};
        fast_full = fast_a * fast_b;
        bypass    = special || !op[2];
        bypass_value = special ? special_value :
                       (op == MULDIV_OP_MUL) ? fast_full[31:0] : fast_full[63:32];
    end
`else
    // Only the divide corner cases skip the iterative path
    always_comb begin
        bypass       = special;
        bypass_value = special_value;
    end
`endif

    cpu_muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_q[2]),
        .hi_in   (work_hi),
        .lo_in   (work_lo),
        .operand (work_operand),
        .hi_out  (step_hi),
        .lo_out  (step_lo)
    );

    // Final-iteration sign fix and result select
    always_comb begin
        last_iter     = (counter == CNT_W'(XLEN-1));
        product       = {step_hi, step_lo};
        product_fixed = neg_result ? (~product + 64'd1) : product;
        case (op_q)
            MULDIV_OP_MUL:                                    calc_result = product_fixed[31:0];
            MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_MULHU: calc_result = product_fixed[63:32];
            MULDIV_OP_DIV, MULDIV_OP_DIVU:                    calc_result = negate_if(neg_result, step_lo);
            default:                                          calc_result = negate_if(neg_rem, step_hi);
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state logic and status outputs
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) next_state = bypass ? ST_FINISH : ST_CALC;
            end
            ST_CALC: begin
                busy = 1'b1;
                if (abort)          next_state = ST_IDLE;
                else if (last_iter) next_state = ST_FINISH;
            end
            ST_FINISH: begin
                done = 1'b1;
                if (accept) next_state = bypass ? ST_FINISH : ST_CALC;
                else        next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter      <= '0;
            op_q         <= MULDIV_OP_MUL;
            work_hi      <= '0;
            work_lo      <= '0;
            work_operand <= '0;
            neg_result   <= 1'b0;
            neg_rem      <= 1'b0;
            result       <= '0;
        end else if (accept) begin
            op_q         <= op;
            counter      <= '0;
            neg_result   <= a_neg ^ b_neg;
            neg_rem      <= a_neg;
            work_hi      <= '0;
            work_lo      <= op[2] ? a_mag : b_mag;
            work_operand <= op[2] ? b_mag : a_mag;
            if (bypass) result <= bypass_value;
        end else if (state == ST_CALC && !abort) begin
            work_hi <= step_hi;
            work_lo <= step_lo;
            counter <= counter + 1'b1;
            if (last_iter) result <= calc_result;
        end
    end

endmodule

// File: doc/cpu_muldiv.md
Name: cpu_muldiv

Overview:
- Multi-cycle execution unit for the RV32M multiply/divide instructions.
- The combinational ALU decodes these opcodes as valid but does not compute them; this block computes them.
- The execute stage issues one request (op, operands) and stalls on `busy`. The unit returns one result with a single-cycle `done` strobe.
- Iterative shift-add multiplier and restoring divider share one 64-bit working register.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, width of the iteration counter; must cover XLEN+1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; accepted only when busy=0.
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- operand_a  in  32  rs1 value (multiplicand/dividend).
- operand_b  in  32  rs2 value (multiplier/divisor).
- abort  in  1  pipeline flush; cancels the in-flight operation.
- busy  out  1  high from the cycle after acceptance until done is asserted.
- done  out  1  one-cycle strobe; result is valid in this cycle.
- result  out  32  registered result; held until the next accepted start.

Behaviour:
- Reset values: busy=0, done=0, result=0, state=IDLE, counter=0.
- Reset asserted mid-operation discards the operation immediately; no done is produced.
- States: IDLE, CALC, FINISH.
- IDLE:
  - start=1 latches op and operands and computes operand magnitudes and result sign.
  - Signedness of a: MULH, MULHSU, DIV, REM.
  - Signedness of b: MULH, DIV, REM.
  - Next state is CALC with counter=0, or FINISH directly for a special case (see below).
- CALC: runs exactly 32 iterations (counter 0..31), then moves to FINISH.
  - Multiply: one unsigned shift-add step per cycle on magnitudes, building a 64-bit product.
  - Divide: one restoring step per cycle. Compute remainder<<1 | next dividend bit, trial subtract the divisor, and set the quotient bit if the result is non-negative.
- FINISH:
  - done=1 for exactly one cycle; result register is loaded on the transition into FINISH; next state is IDLE.
  - busy=0 in FINISH, so start may be asserted in the FINISH cycle and is accepted.
- Sign fix, applied on the transition into FINISH:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Result select:
  - MUL gives product[31:0]; MULH, MULHSU and MULHU give product[63:32].
  - DIV and DIVU give the quotient; REM and REMU give the remainder.
- Latency:
  - Start accepted at edge N; CALC covers cycles N+1..N+32; done is high in cycle N+33.
  - Special cases: done is high in cycle N+1.
- Special cases, detected in IDLE and bypassing CALC:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give operand_a.
  - DIV with 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
  - Multiply by zero is not special-cased.
- start while busy=1 is ignored, with no effect on state.
- abort in CALC returns to IDLE on the next edge: done stays 0, result is unchanged.
- abort has no effect in IDLE.
- abort in FINISH does not suppress the done strobe.
- abort and start asserted together in IDLE: abort wins and the request is dropped.
- All arithmetic is mod 2^32 on outputs. Intermediate remainder is 33 bits; product is 64 bits.

Optional Feature:
- Macro: CPU_MULDIV_FAST_MUL_EN.
- Defined: multiply ops use a combinational 33x33 signed multiplier, with operands sign- or zero-extended per op. IDLE goes directly to FINISH, so done arrives at N+1. Division is unchanged.
- Undefined: multiply uses the 32-cycle iterative path described above. No DSP inference is required.

Decomposition:
- Shared header/package holds:
  - op encodings (MULDIV_OP_MUL..MULDIV_OP_REMU, aligned with the existing INST_ARLOG_* M-extension constants);
  - state encodings;
  - the two constants 0xFFFFFFFF (div-by-zero quotient) and 0x80000000 (overflow dividend).
- One natural sub-module: cpu_muldiv_step. It is purely combinational, performing one shift-add or restoring-subtract iteration on {hi, lo, operand} selected by an is_div flag. The FSM, counter, sign logic and result register stay in cpu_muldiv.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> done exactly 33 cycles after the start edge, result 0xFFFFFFEB; busy high for the 32 CALC cycles.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHSU with the same operands -> 0xC0000000; MULHU with the same operands -> 0x40000000.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU with the same operands -> 2.
- DIVU a=5, b=0 -> done 1 cycle after start, 0xFFFFFFFF; REM a=5, b=0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in 1 cycle.
- Start DIV, pulse abort at CALC iteration 10 -> no done, busy=0 next cycle, result unchanged. A following MUL 6*7 -> 42. start pulses while busy are ignored.
- Assert rst mid-CALC -> busy/done/result=0 asynchronously. With CPU_MULDIV_FAST_MUL_EN: MUL 6*7 -> done at N+1, result 42, and DIV latency is still 33.
